// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: operation encoding, result predictor and
// scoreboard error-flag bit positions.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  // Widest operand the predictor handles; callers zero-extend their
  // operands to this width and truncate the result to 2*DATA_W.
  localparam int unsigned PRED_W = 32;

  // Sticky error flag bit positions.
  localparam int unsigned ERR_OVERFLOW = 0;
  localparam int unsigned ERR_UNEXP    = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;
  localparam int unsigned ERR_W        = 3;

  // True for operations that produce a result the DUT will answer.
  function automatic logic is_alu_op(input logic [2:0] op);
    logic res;
    res = 1'b0;
    case (op)
      add_op, and_op, xor_op, mul_op: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

  // Expected TinyALU result. Operands are zero-extended before the
  // operation so add keeps its carry and mul keeps the full product.
  function automatic logic [2*PRED_W-1:0] predict(
    input logic [2:0]        op,
    input logic [PRED_W-1:0] a,
    input logic [PRED_W-1:0] b
  );
    logic [2*PRED_W-1:0] ax;
    logic [2*PRED_W-1:0] bx;
    logic [2*PRED_W-1:0] res;
    ax  = {{PRED_W{1'b0}}, a};
    bx  = {{PRED_W{1'b0}}, b};
    res = '0;
    case (op)
      add_op:  res = ax + bx;
      and_op:  res = ax & bx;
      xor_op:  res = ax ^ bx;
      mul_op:  res = ax * bx;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Synchronous FIFO holding predicted results in issue order.
// Push and pop may coincide whenever the FIFO is non-empty, including
// when full; flush empties it and overrides push/pop.
module sb_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  // Pointer and occupancy next-state; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tinyalu_scoreboard_q.sv
// Queue-based TinyALU result checker: predicts each issued command into
// an in-order queue and compares every DUT response against the head.
module tinyalu_scoreboard_q
  import tinyalu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd_op,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic                   rsp_valid,
  input  logic [2*DATA_W-1:0]    rsp_result,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   mismatch,
  output logic [2*DATA_W-1:0]    last_exp,
  output logic [2*DATA_W-1:0]    last_got,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [2:0]             err_flags
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  logic [RES_W-1:0] pred;
  logic [RES_W-1:0] head;
  logic             q_full;
  logic             q_empty;

  logic             cmd_push;
  logic             cmd_flush;
  logic             rsp_hit;
  logic             rsp_unexp;
  logic             rsp_bad;
  logic             timeout_hit;
  logic             q_pop;
  logic             overflow;
  logic             fail_event;

  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             mism_q, mism_d;
  logic [RES_W-1:0] exp_q, exp_d;
  logic [RES_W-1:0] got_q, got_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign pred = RES_W'(predict(cmd_op, PRED_W'(cmd_a), PRED_W'(cmd_b)));

  sb_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_push),
    .pop     (q_pop),
    .flush   (cmd_flush),
    .wr_data (pred),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (outstanding)
  );

  // Event decode. A response always compares against the pre-cycle head,
  // and a response in the timeout cycle pre-empts the timeout drop.
  always_comb begin
    cmd_push    = cmd_valid && is_alu_op(cmd_op);
    cmd_flush   = cmd_valid && (cmd_op == rst_op);
    rsp_hit     = rsp_valid && !q_empty;
    rsp_unexp   = rsp_valid && q_empty;
    rsp_bad     = rsp_hit && (head != rsp_result);
    timeout_hit = !q_empty && !rsp_valid && (wd_q == WD_W'(TIMEOUT - 1));
    q_pop       = rsp_hit || timeout_hit;
    overflow    = cmd_push && q_full && !q_pop;
    fail_event  = rsp_bad || rsp_unexp || timeout_hit;
  end

  // Watchdog: cycles the current head has been waiting.
  always_comb begin
    wd_d = wd_q;
    if (cmd_flush || q_pop || q_empty) wd_d = '0;
    else                               wd_d = wd_q + WD_W'(1);
  end

  // Counters, mismatch pulse, capture registers and sticky flags.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    exp_d  = exp_q;
    got_d  = got_q;
    err_d  = err_q;
    mism_d = fail_event;
    if (rsp_hit && !rsp_bad && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
    if (fail_event && (fail_q != '1))          fail_d = fail_q + CNT_W'(1);
    if (rsp_bad) begin
      exp_d = head;
      got_d = rsp_result;
    end
    if (overflow)    err_d[ERR_OVERFLOW] = 1'b1;
    if (rsp_unexp)   err_d[ERR_UNEXP]    = 1'b1;
    if (timeout_hit) err_d[ERR_TIMEOUT]  = 1'b1;
  end

  // Checker state registers; reset overrides every same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q   <= '0;
      pass_q <= '0;
      fail_q <= '0;
      mism_q <= 1'b0;
      exp_q  <= '0;
      got_q  <= '0;
      err_q  <= '0;
    end else begin
      wd_q   <= wd_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      mism_q <= mism_d;
      exp_q  <= exp_d;
      got_q  <= got_d;
      err_q  <= err_d;
    end
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign mismatch  = mism_q;
  assign last_exp  = exp_q;
  assign last_got  = got_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_tinyalu_scoreboard_q.sv
// Directed bench for tinyalu_scoreboard_q: a vector table for single
// command/response pairs plus hand-written multi-cycle sequences.
module tb_tinyalu_scoreboard_q;
  import tinyalu_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 4;
  localparam int unsigned TO  = 16;
  localparam int unsigned CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic [2:0]     cmd_op;
  logic [DW-1:0]  cmd_a, cmd_b;
  logic           rsp_valid;
  logic [2*DW-1:0] rsp_result;
  logic [CW-1:0]  pass_cnt, fail_cnt;
  logic           mismatch;
  logic [2*DW-1:0] last_exp, last_got;
  logic [$clog2(DEP):0] outstanding;
  logic [2:0]     err_flags;

  int checks = 0;
  int failures = 0;

  tinyalu_scoreboard_q #(
    .DATA_W  (DW),
    .DEPTH   (DEP),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .mismatch    (mismatch),
    .last_exp    (last_exp),
    .last_got    (last_got),
    .outstanding (outstanding),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Apply inputs for one cycle; returns at the following negedge, after
  // the rising edge has taken effect.
  task automatic tick(input logic cv, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic rv, input logic [15:0] r);
    cmd_valid  = cv;
    cmd_op     = op;
    cmd_a      = a;
    cmd_b      = b;
    rsp_valid  = rv;
    rsp_result = r;
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, no_op, 8'h00, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    tick(1'b1, op, a, b, 1'b0, 16'h0000);
  endtask

  task automatic rsp(input logic [15:0] r);
    tick(1'b0, no_op, 8'h00, 8'h00, 1'b1, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'd0);
    chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    chk({tag, "_mism"}, 32'(mismatch), 32'd0);
    chk({tag, "_lexp"}, 32'(last_exp), 32'd0);
    chk({tag, "_lgot"}, 32'(last_got), 32'd0);
    chk({tag, "_outs"}, 32'(outstanding), 32'd0);
    chk({tag, "_err"},  32'(err_flags), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{add_op, 8'hFF, 8'h01, 16'h0100};
    vecs[1] = '{add_op, 8'h03, 8'h04, 16'h0007};
    vecs[2] = '{and_op, 8'hF0, 8'h3C, 16'h0030};
    vecs[3] = '{xor_op, 8'hAA, 8'h55, 16'h00FF};
    vecs[4] = '{mul_op, 8'hFF, 8'hFF, 16'hFE01};
    vecs[5] = '{mul_op, 8'h02, 8'h03, 16'h0006};
    vecs[6] = '{add_op, 8'h80, 8'h80, 16'h0100};
    vecs[7] = '{xor_op, 8'h0F, 8'h0F, 16'h0000};
    vecs[8] = '{and_op, 8'h00, 8'hFF, 16'h0000};
    vecs[9] = '{mul_op, 8'h10, 8'h10, 16'h0100};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = no_op; cmd_a = '0; cmd_b = '0;
    rsp_valid = 1'b0; rsp_result = '0;
    @(negedge clk);
    do_reset();
    chk_all_zero("reset");

    // Table: one command then its correct response.
    for (int i = 0; i < 10; i++) begin
      cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      chk("vec_outs1", 32'(outstanding), 32'd1);
      rsp(vecs[i].res);
      chk("vec_pass", 32'(pass_cnt), 32'(i + 1));
      chk("vec_fail", 32'(fail_cnt), 32'd0);
      chk("vec_mism", 32'(mismatch), 32'd0);
      chk("vec_outs0", 32'(outstanding), 32'd0);
    end

    // Four commands in flight, answered in order.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      chk("b2b_fill", 32'(outstanding), 32'(i));
    end
    for (int i = 1; i <= 4; i++) begin
      rsp(vecs[i].res);
      chk("b2b_drain", 32'(outstanding), 32'(4 - i));
    end
    chk("b2b_pass", 32'(pass_cnt), 32'd4);
    chk("b2b_fail", 32'(fail_cnt), 32'd0);

    // Wrong answer: mul 2*3 answered with 7.
    do_reset();
    cmd(mul_op, 8'h02, 8'h03);
    rsp(16'h0007);
    chk("mm_fail", 32'(fail_cnt), 32'd1);
    chk("mm_pulse", 32'(mismatch), 32'd1);
    chk("mm_exp", 32'(last_exp), 32'h0006);
    chk("mm_got", 32'(last_got), 32'h0007);
    idle();
    chk("mm_pulse_end", 32'(mismatch), 32'd0);
    chk("mm_fail_hold", 32'(fail_cnt), 32'd1);

    // Unexpected response, then overflow, then push+pop while full.
    do_reset();
    rsp(16'h1234);
    chk("unexp_err", 32'(err_flags), 32'b010);
    chk("unexp_fail", 32'(fail_cnt), 32'd1);
    chk("unexp_mism", 32'(mismatch), 32'd1);
    chk("unexp_lgot", 32'(last_got), 32'd0);
    for (int i = 0; i <= DEP; i++) cmd(add_op, 8'(i), 8'(i));
    chk("ovf_outs", 32'(outstanding), 32'(DEP));
    chk("ovf_err", 32'(err_flags), 32'b011);
    chk("ovf_fail", 32'(fail_cnt), 32'd1);
    tick(1'b1, add_op, 8'h05, 8'h05, 1'b1, 16'h0000);
    chk("fullpp_outs", 32'(outstanding), 32'(DEP));
    chk("fullpp_pass", 32'(pass_cnt), 32'd1);
    rsp(16'h0002); rsp(16'h0004); rsp(16'h0006); rsp(16'h000A);
    chk("fullpp_drain_pass", 32'(pass_cnt), 32'd5);
    chk("fullpp_drain_fail", 32'(fail_cnt), 32'd1);
    chk("fullpp_drain_outs", 32'(outstanding), 32'd0);

    // Timeout, watchdog restart for the next head, then a late response.
    do_reset();
    cmd(add_op, 8'h01, 8'h01);
    cmd(add_op, 8'h02, 8'h02);
    for (int i = 0; i < TO - 2; i++) idle();
    chk("to_before_err", 32'(err_flags), 32'b000);
    chk("to_before_outs", 32'(outstanding), 32'd2);
    idle();
    chk("to_err", 32'(err_flags), 32'b100);
    chk("to_outs", 32'(outstanding), 32'd1);
    chk("to_fail", 32'(fail_cnt), 32'd1);
    chk("to_mism", 32'(mismatch), 32'd1);
    for (int i = 0; i < TO - 1; i++) idle();
    chk("to2_before_outs", 32'(outstanding), 32'd1);
    chk("to2_before_fail", 32'(fail_cnt), 32'd1);
    idle();
    chk("to2_outs", 32'(outstanding), 32'd0);
    chk("to2_fail", 32'(fail_cnt), 32'd2);
    rsp(16'h0002);
    chk("late_err", 32'(err_flags), 32'b110);
    chk("late_fail", 32'(fail_cnt), 32'd3);

    // Response arriving in the timeout cycle wins.
    do_reset();
    cmd(xor_op, 8'h0F, 8'hF0);
    for (int i = 0; i < TO - 1; i++) idle();
    rsp(16'h00FF);
    chk("race_pass", 32'(pass_cnt), 32'd1);
    chk("race_fail", 32'(fail_cnt), 32'd0);
    chk("race_err", 32'(err_flags), 32'b000);
    chk("race_outs", 32'(outstanding), 32'd0);

    // rst_op flush keeps counters; no_op ignored; push+pop on empty queue.
    do_reset();
    cmd(add_op, 8'h01, 8'h02);
    rsp(16'h0003);
    cmd(add_op, 8'h01, 8'h02);
    rsp(16'h0004);
    for (int i = 0; i < 3; i++) cmd(and_op, 8'hFF, 8'h0F);
    chk("flush_pre_outs", 32'(outstanding), 32'd3);
    cmd(rst_op, 8'h00, 8'h00);
    chk("flush_outs", 32'(outstanding), 32'd0);
    chk("flush_pass", 32'(pass_cnt), 32'd1);
    chk("flush_fail", 32'(fail_cnt), 32'd1);
    chk("flush_err", 32'(err_flags), 32'b000);
    cmd(no_op, 8'h01, 8'h01);
    chk("noop_outs", 32'(outstanding), 32'd0);
    tick(1'b1, mul_op, 8'h03, 8'h05, 1'b1, 16'h000F);
    chk("emptypp_err", 32'(err_flags), 32'b010);
    chk("emptypp_fail", 32'(fail_cnt), 32'd2);
    chk("emptypp_outs", 32'(outstanding), 32'd1);
    rsp(16'h000F);
    chk("emptypp_pass", 32'(pass_cnt), 32'd2);

    // Reset mid-stream, with a command presented during reset.
    cmd(add_op, 8'h01, 8'h01);
    reset = 1'b1;
    tick(1'b1, add_op, 8'h02, 8'h02, 1'b1, 16'h0009);
    reset = 1'b0;
    chk_all_zero("midreset");

    // Counter saturation.
    for (int i = 0; i < 20; i++) rsp(16'h0000);
    chk("sat_fail", 32'(fail_cnt), 32'hF);
    for (int i = 0; i < 20; i++) begin
      cmd(add_op, 8'h00, 8'h00);
      rsp(16'h0000);
    end
    chk("sat_pass", 32'(pass_cnt), 32'hF);
    chk("sat_fail_hold", 32'(fail_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
